core_dmem_responder: RTL

- Data-memory responder: the slave end of the LSU load/store request interface in the EX stage.
- Accepts one request at a time over a valid/ready handshake and holds an internal word-addressed memory array.
- Applies byte-masked writes and returns read data after a fixed, parameterised latency.
- Replaces the DPI-C memory model for synthesisable and standalone simulation.

---
 rtl/core_dmem_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/core_dmem_responder.sv
// Data-memory responder for the LSU request interface.
// Takes one load/store at a time over valid/ready, runs it against an
// internal word-addressed array with byte-masked writes, and presents the
// response a fixed number of cycles after the request was accepted.
module core_dmem_responder #(
    parameter int                    XLEN       = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [XLEN/8-1:0]     req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [NB-1:0]         wmask_q, wmask_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [XLEN-1:0]       mem [DEPTH];

    // Operands of the execute action. With LATENCY=1 the execute edge is the
    // acceptance edge itself, so the request pins are used directly; in every
    // other case the request has already been latched.
    logic                  op_wen;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [XLEN-1:0]       op_wdata;
    logic [NB-1:0]         op_wmask;
    logic [ADDR_WIDTH:0]   diff_full;
    logic [ADDR_WIDTH-1:0] word;
    logic                  oow;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic                  exec;
    logic                  mem_we;

    // Select execute operands: live request while idle, latched copy otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_wen   = req_wen;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_wmask = req_wmask;
        end else begin
            op_wen   = wen_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_wmask = wmask_q;
        end
    end

    // Address decode: the extra top bit of the subtraction is the borrow,
    // which flags addresses below the window; byte-offset bits are dropped.
    always_comb begin
        diff_full = {1'b0, op_addr} - {1'b0, BASE_ADDR};
        word      = diff_full[ADDR_WIDTH-1:0] >> OFF;
        oow       = diff_full[ADDR_WIDTH] || ((word >> DEPTH_LOG2) != '0);
        op_idx    = word[DEPTH_LOG2-1:0];
    end

    // Next-state, request latch and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        exec    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        exec    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // <= also catches a stray zero so the FSM can never stall here.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                    exec    = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (exec) begin
            err_d   = oow;
            rdata_d = (!oow && !op_wen) ? mem[op_idx] : '0;
        end
    end

    // A write only happens on an in-window store's execute edge; reset
    // blocks it so a store caught by reset never lands.
    assign mem_we = exec && !oow && op_wen && rst_n;

    // State, request latch and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-masked array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (op_wmask[i]) begin
                    mem[op_idx][i*8 +: 8] <= op_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
